// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand/result handshake bundle for pipelined_addsub.
//   master: drives in_valid, in1, in2, cin, op, out_ready (and sat when enabled)
//   slave : drives in_ready, out_valid, out, cout, zero, neg, ovf
// Optional feature macro: PIPELINED_ADDSUB_SAT_EN adds the sat signal.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic             op;
`ifdef PIPELINED_ADDSUB_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             zero;
  logic             neg;
  logic             ovf;

`ifdef PIPELINED_ADDSUB_SAT_EN
  modport master (
    output in_valid, in1, in2, cin, op, sat, out_ready,
    input  in_ready, out_valid, out, cout, zero, neg, ovf
  );
  modport slave (
    input  in_valid, in1, in2, cin, op, sat, out_ready,
    output in_ready, out_valid, out, cout, zero, neg, ovf
  );
`else
  modport master (
    output in_valid, in1, in2, cin, op, out_ready,
    input  in_ready, out_valid, out, cout, zero, neg, ovf
  );
  modport slave (
    input  in_valid, in1, in2, cin, op, out_ready,
    output in_ready, out_valid, out, cout, zero, neg, ovf
  );
`endif
endinterface

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: adder/subtractor with the carry chain cut into CHUNK-bit
// slices, one register stage per slice, valid/ready on both sides.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipelined_addsub_if.slave (operands in, result + flags out)
// Optional feature macro: PIPELINED_ADDSUB_SAT_EN enables the unsigned clamp
// selected per transaction by bus.sat.
module pipelined_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int unsigned STAGES = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned NREG   = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int unsigned LAST   = STAGES - 1;
  localparam int unsigned MSB    = WIDTH - 1;

  logic             advance;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  // Inter-stage registers (stage LAST writes the output register instead)
  logic             st_vld [NREG];
  logic [WIDTH-1:0] st_a   [NREG];
  logic [WIDTH-1:0] st_b   [NREG];
  logic [WIDTH-1:0] st_s   [NREG];
  logic             st_c   [NREG];
  logic             st_op  [NREG];

  // Per-stage inputs and slice results
  logic             src_vld [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [WIDTH-1:0] src_s   [STAGES];
  logic             src_c   [STAGES];
  logic             src_op  [STAGES];
  logic [WIDTH-1:0] nxt_s   [STAGES];
  logic             nxt_c   [STAGES];

`ifdef PIPELINED_ADDSUB_SAT_EN
  logic             st_sat  [NREG];
  logic             src_sat [STAGES];
`endif

  logic             res_valid;
  logic [WIDTH-1:0] res_out;
  logic             res_cout;
  logic             res_zero;
  logic             res_neg;
  logic             res_ovf;

  logic [WIDTH-1:0] fin_out;
  logic             fin_cout;
  logic             fin_ovf;

  // Whole pipeline moves together; a full output register blocks everything
  assign advance      = ~res_valid | bus.out_ready;
  assign bus.in_ready = advance;

  // Subtraction as A + ~B + ~borrow
  assign b_in = bus.op ? ~bus.in2 : bus.in2;
  assign c_in = bus.op ? ~bus.cin : bus.cin;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int unsigned LO = i * CHUNK;
    localparam int unsigned SW = (WIDTH - LO < CHUNK) ? WIDTH - LO : CHUNK;
    localparam int unsigned PW = SW + 1;
    localparam logic [WIDTH-1:0] MASK = ((WIDTH'(1) << SW) - WIDTH'(1)) << LO;

    logic [SW:0] part;

    if (i == 0) begin : g_head
      assign src_vld[i] = bus.in_valid;
      assign src_a[i]   = bus.in1;
      assign src_b[i]   = b_in;
      assign src_s[i]   = '0;
      assign src_c[i]   = c_in;
      assign src_op[i]  = bus.op;
`ifdef PIPELINED_ADDSUB_SAT_EN
      assign src_sat[i] = bus.sat;
`endif
    end else begin : g_body
      assign src_vld[i] = st_vld[i-1];
      assign src_a[i]   = st_a[i-1];
      assign src_b[i]   = st_b[i-1];
      assign src_s[i]   = st_s[i-1];
      assign src_c[i]   = st_c[i-1];
      assign src_op[i]  = st_op[i-1];
`ifdef PIPELINED_ADDSUB_SAT_EN
      assign src_sat[i] = st_sat[i-1];
`endif
    end

    // Slice add; the top bit of part is the carry into the next slice
    assign part     = PW'(src_a[i][LO +: SW]) + PW'(src_b[i][LO +: SW]) + PW'(src_c[i]);
    assign nxt_s[i] = (src_s[i] & ~MASK) | (WIDTH'(part[SW-1:0]) << LO);
    assign nxt_c[i] = part[SW];

    if (i < LAST) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          st_vld[i] <= 1'b0;
          st_a[i]   <= '0;
          st_b[i]   <= '0;
          st_s[i]   <= '0;
          st_c[i]   <= 1'b0;
          st_op[i]  <= 1'b0;
`ifdef PIPELINED_ADDSUB_SAT_EN
          st_sat[i] <= 1'b0;
`endif
        end else if (advance) begin
          st_vld[i] <= src_vld[i];
          st_a[i]   <= src_a[i];
          st_b[i]   <= src_b[i];
          st_s[i]   <= nxt_s[i];
          st_c[i]   <= nxt_c[i];
          st_op[i]  <= src_op[i];
`ifdef PIPELINED_ADDSUB_SAT_EN
          st_sat[i] <= src_sat[i];
`endif
        end
      end
    end
  end

  // Final stage: flags from the raw sum, optional clamp ahead of the register
  always_comb begin
    fin_cout = src_op[LAST] ? ~nxt_c[LAST] : nxt_c[LAST];
    fin_ovf  = (src_a[LAST][MSB] == src_b[LAST][MSB]) &&
               (nxt_s[LAST][MSB] != src_a[LAST][MSB]);
    fin_out  = nxt_s[LAST];
`ifdef PIPELINED_ADDSUB_SAT_EN
    if (src_sat[LAST] && fin_cout) begin
      fin_out = src_op[LAST] ? '0 : '1;
    end
`endif
  end

  // Output register; data only loads with a valid result so it holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_out   <= '0;
      res_cout  <= 1'b0;
      res_zero  <= 1'b0;
      res_neg   <= 1'b0;
      res_ovf   <= 1'b0;
    end else if (advance) begin
      res_valid <= src_vld[LAST];
      if (src_vld[LAST]) begin
        res_out  <= fin_out;
        res_cout <= fin_cout;
        res_zero <= (nxt_s[LAST] == '0);
        res_neg  <= nxt_s[LAST][MSB];
        res_ovf  <= fin_ovf;
      end
    end
  end

  assign bus.out_valid = res_valid;
  assign bus.out       = res_out;
  assign bus.cout      = res_cout;
  assign bus.zero      = res_zero;
  assign bus.neg       = res_neg;
  assign bus.ovf       = res_ovf;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed vectors against an 8/4 and a 13/4 instance.
module tb_pipelined_addsub;
`ifdef PIPELINED_ADDSUB_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(8))  bus   ();
  pipelined_addsub_if #(.WIDTH(13)) bus13 ();

  pipelined_addsub #(.WIDTH(8), .CHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pipelined_addsub #(.WIDTH(13), .CHUNK(4)) dut13 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus13)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction on the 8-bit unit; e_out is the raw result
  task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic o, input logic s,
                         input logic [7:0] e_out, input logic e_cout, input logic e_zero,
                         input logic e_neg, input logic e_ovf);
    int lat;
    logic [7:0] exp_out;
    exp_out = (SAT_ON && s && e_cout) ? (o ? 8'h00 : 8'hFF) : e_out;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in1 = a;
    bus.in2 = b;
    bus.cin = c;
    bus.op  = o;
`ifdef PIPELINED_ADDSUB_SAT_EN
    bus.sat = s;
`endif
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_out"},  32'(bus.out),  32'(exp_out));
    check({tag, "_cout"}, 32'(bus.cout), 32'(e_cout));
    check({tag, "_zero"}, 32'(bus.zero), 32'(e_zero));
    check({tag, "_neg"},  32'(bus.neg),  32'(e_neg));
    check({tag, "_ovf"},  32'(bus.ovf),  32'(e_ovf));
  endtask

  initial begin
    int cyc;
    int idx;
    int lat;
    bit stalled_prev;
    logic [7:0] held;
    logic [7:0] got[$];

    bus.in_valid = 1'b0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.cin = 1'b0;
    bus.op  = 1'b0;
    bus.out_ready = 1'b1;
    bus13.in_valid = 1'b0;
    bus13.in1 = '0;
    bus13.in2 = '0;
    bus13.cin = 1'b0;
    bus13.op  = 1'b0;
    bus13.out_ready = 1'b1;
`ifdef PIPELINED_ADDSUB_SAT_EN
    bus.sat = 1'b0;
    bus13.sat = 1'b0;
`endif

    // Reset state
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out",       32'(bus.out),       32'd0);
    check("rst_cout",      32'(bus.cout),      32'd0);
    check("rst_zero",      32'(bus.zero),      32'd0);
    check("rst_neg",       32'(bus.neg),       32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    #10 rst_n = 1'b1;

    // Directed vectors (raw results hand-computed)
    run_one("add_7f_01",   8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    run_one("sub_10_20",   8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_one("sub_20_20_b", 8'h20, 8'h20, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    run_one("add_ff_01",   8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    run_one("add_ff_01_s", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    run_one("sub_03_05_s", 8'h03, 8'h05, 1'b0, 1'b1, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0);
    run_one("sub_05_03_s", 8'h05, 8'h03, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("add_80_80",   8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    run_one("add_0f_01_c", 8'h0F, 8'h01, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream of i+i with a 3-cycle downstream stall
    cyc = 0;
    idx = 0;
    stalled_prev = 1'b0;
    held = '0;
    while (got.size() < 6 && cyc < 60) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 3 && cyc < 6);
      bus.in_valid  = (idx < 6);
      bus.in1 = 8'(idx + 1);
      bus.in2 = 8'(idx + 1);
      bus.cin = 1'b0;
      bus.op  = 1'b0;
`ifdef PIPELINED_ADDSUB_SAT_EN
      bus.sat = 1'b0;
`endif
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        if (stalled_prev) check("stall_hold", 32'(bus.out), 32'(held));
        held = bus.out;
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out);
      if (bus.in_valid && bus.in_ready) idx++;
      cyc++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < got.size(); i++) begin
      check($sformatf("stream_%0d", i), 32'(got[i]), 32'(8'(2 * (i + 1))));
    end
    #1;
    check("stream_no_extra", 32'(bus.out_valid), 32'd0);

    // Two transactions in flight, then an asynchronous reset pulse
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in1 = 8'h11;
    bus.in2 = 8'h22;
    @(negedge clk);
    bus.in1 = 8'h01;
    bus.in2 = 8'h02;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("inflight_valid", 32'(bus.out_valid), 32'd1);
    check("inflight_out",   32'(bus.out),       32'h33);
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out",       32'(bus.out),       32'd0);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_valid_%0d", i), 32'(bus.out_valid), 32'd0);
      check($sformatf("post_rst_out_%0d", i),   32'(bus.out),       32'd0);
    end

    // 13-bit unit, 4 stages with a 1-bit top slice
    @(negedge clk);
    bus13.in_valid = 1'b1;
    bus13.in1 = 13'h1FFF;
    bus13.in2 = 13'h0001;
    @(negedge clk);
    bus13.in_valid = 1'b0;
    lat = 1;
    while (!bus13.out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("w13_latency", 32'(lat),          32'd4);
    check("w13_out",     32'(bus13.out),    32'h0000);
    check("w13_cout",    32'(bus13.cout),   32'd1);
    check("w13_zero",    32'(bus13.zero),   32'd1);
    check("w13_ovf",     32'(bus13.ovf),    32'd0);

    @(negedge clk);
    bus13.in_valid = 1'b1;
    bus13.in1 = 13'h0800;
    bus13.in2 = 13'h0001;
    bus13.cin = 1'b0;
    bus13.op  = 1'b1;
    @(negedge clk);
    bus13.in_valid = 1'b0;
    lat = 1;
    while (!bus13.out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("w13_sub_latency", 32'(lat),        32'd4);
    check("w13_sub_out",     32'(bus13.out),  32'h07FF);
    check("w13_sub_cout",    32'(bus13.cout), 32'd0);
    check("w13_sub_neg",     32'(bus13.neg),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined adder/subtractor for the GCD datapath and any later arithmetic units. The carry chain is split into CHUNK-bit slices, one register stage per slice, so wide operands close timing at full clock rate. Operands enter and results leave on valid/ready handshakes, with one transaction accepted per cycle. Each result carries carry/borrow, zero, negative and signed-overflow flags, so the GCD controller can compare and subtract in one unit.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥1)
- CHUNK, 4, bits resolved per pipeline stage (1..WIDTH); STAGES = ceil(WIDTH/CHUNK); last slice may be narrower

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand transaction valid
- in_ready  out  1  block can accept a transaction this cycle
- in1  in  WIDTH  operand A
- in2  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- op  in  1  0 = A+B+cin, 1 = A−B−cin
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out  out  WIDTH  result
- cout  out  1  add: carry out; sub: borrow out (1 when A < B+cin unsigned)
- zero  out  1  raw result == 0
- neg  out  1  raw result MSB
- ovf  out  1  two's-complement signed overflow
- sat  in  1  present only with PIPELINED_ADDSUB_SAT_EN (see Configuration)

## Operation
- Sub: B is inverted and the slice-0 carry-in is ~cin; cout is the inverse of the final carry.
- Stage i adds slice i of A and B' plus the carry registered by stage i−1. Unprocessed upper slices and op travel with the transaction; finished lower result slices are delayed so the whole word leaves together.
- Every stage register has a valid bit. Global advance = ~out_valid | out_ready. All stages shift when advance is high and hold when it is low.
- in_ready = advance, combinational from out_valid/out_ready. The transfer happens when in_valid & in_ready.
- Flags are computed in the final stage from the full raw sum: ovf = (A[MSB]==B'[MSB]) & (sum[MSB]!=A[MSB]).
- Bubbles propagate as invalid stages and are not collapsed.
- Results leave in acceptance order with no loss or duplication under any out_ready pattern.
- Reset asserted mid-operation clears all stage valids at once, and in-flight transactions are discarded.

## Timing
- Reset values: out_valid 0, out 0, cout 0, zero 0, neg 0, ovf 0. Internal stage registers are 0 and invalid. in_ready is 1 once out_valid is 0.
- Latency is STAGES cycles. A transaction accepted at edge k shows out_valid=1 after edge k+STAGES−1 when not stalled (STAGES=1: a registered output, visible the cycle after acceptance).
- Throughput is 1 transaction/cycle while out_ready=1.
- While out_valid & ~out_ready, out and the flags hold stable and in_ready=0.
- Simultaneous output pop and input push in the same cycle is allowed at full rate.
- Reset release is synchronised by the system. The first accept can occur on the first edge with rst_n high.

## Configuration
- PIPELINED_ADDSUB_SAT_EN defined:
  - the sat input exists and travels with the transaction;
  - when sat=1, out is clamped unsigned: add with cout=1 → all ones; sub with cout=1 → 0;
  - cout/zero/neg/ovf always describe the raw, unclamped result;
  - latency is unchanged, because the clamp sits in front of the output register.
- Not defined: no sat port, no clamp logic, and out is always the raw result.

## Test plan
- WIDTH=8, CHUNK=4, op=0, 0x7F+0x01, cin=0 → after 2 cycles out=0x80, cout=0, ovf=1, neg=1, zero=0.
- op=1, 0x10−0x20, cin=0 → out=0xF0, cout=1, neg=1, ovf=0. Then 0x20−0x20 with cin=1 → out=0xFF, cout=1.
- op=0, 0xFF+0x01 → out=0x00, zero=1, cout=1. With PIPELINED_ADDSUB_SAT_EN and sat=1 → out=0xFF, zero=1, cout=1 (flags raw).
- Stream 6 back-to-back adds (i+i, i=1..6) with out_ready held low for 3 cycles mid-stream → in_ready low during the stall, outputs 2,4,6,8,10,12 in order, none lost or repeated.
- Two transactions in flight, then rst_n pulsed low asynchronously between edges → out_valid=0 and out=0 immediately; no stale result appears after release.
- WIDTH=13, CHUNK=4 (4 stages, 1-bit top slice): 0x1FFF+0x0001 → out=0x0000, cout=1, latency 4 cycles.
